// File: rtl/mdu_if.sv
// mdu_if: launch/result bundle between the core control and the iterative
// multiply/divide unit. The control side (master) drives the operands and
// the launch request; the unit (slave) returns status and the write-back port.
interface mdu_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [RD_W-1:0] rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_out;
  logic            ru_wr;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out, ru_wr
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out, ru_wr
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, radix-2, one bit per cycle.
// Operands are reduced to magnitudes at launch, 32 shift-add (multiply) or
// restoring shift-subtract (divide) iterations follow, and the sign is fixed
// up in a final cycle before the write-back pulse.
// Optional build macro MDU_EARLY_OUT_EN: divide by zero, signed divide
// overflow and zero multiply operands bypass the iterations entirely.
module mdu_iter #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  mdu_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t state, state_nxt;

  // Control registers
  logic [4:0]      cnt_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [RD_W-1:0] rd_out_q;

  // Datapath registers (fully reloaded at every launch)
  logic [2:0]        op_q;
  logic [RD_W-1:0]   rd_q;
  logic              a_neg_q;
  logic              b_neg_q;
  logic [XLEN-1:0]   sh_q;    // multiplier (MUL) or dividend (DIV), consumed MSB first
  logic [XLEN-1:0]   opnd_q;  // multiplicand (MUL) or divisor (DIV)
  logic [2*XLEN-1:0] acc_q;   // product, or {remainder, quotient}

  // Two's complement negate when n is set
  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg2_if(input logic n, input logic [2*XLEN-1:0] v);
    return n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Launch decode: operand signedness, magnitudes and work-register routing
  logic            a_signed, b_signed, a_neg_in, b_neg_in, is_div_in;
  logic [XLEN-1:0] a_abs_in, b_abs_in;
  logic            early_out;
  logic [2*XLEN-1:0] acc_init;

  assign a_signed  = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                     (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign b_signed  = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) ||
                     (bus.funct3 == 3'd6);
  assign a_neg_in  = a_signed & bus.rs1_val[XLEN-1];
  assign b_neg_in  = b_signed & bus.rs2_val[XLEN-1];
  assign a_abs_in  = neg_if(a_neg_in, bus.rs1_val);
  assign b_abs_in  = neg_if(b_neg_in, bus.rs2_val);
  assign is_div_in = bus.funct3[2];

`ifdef MDU_EARLY_OUT_EN
  // Special cases preload the accumulator with exactly what the 32
  // iterations would have produced, so the FINISH sign-fix is shared.
  logic div0_in, ovf_in, mzero_in;
  assign div0_in  = is_div_in && (bus.rs2_val == '0);
  assign ovf_in   = is_div_in && !bus.funct3[0] &&
                    (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (bus.rs2_val == '1);
  assign mzero_in = !is_div_in && ((bus.rs1_val == '0) || (bus.rs2_val == '0));
  assign early_out = div0_in || ovf_in || mzero_in;
  always_comb begin
    acc_init = '0;
    if (div0_in)     acc_init = {a_abs_in, {XLEN{1'b1}}};
    else if (ovf_in) acc_init = {{XLEN{1'b0}}, a_abs_in};
  end
`else
  assign early_out = 1'b0;
  assign acc_init  = '0;
`endif

  // One iteration step for each operation class
  logic [2*XLEN-1:0] acc_mul, acc_div;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;

  assign acc_mul = {acc_q[2*XLEN-2:0], 1'b0} +
                   (sh_q[XLEN-1] ? {{XLEN{1'b0}}, opnd_q} : {(2*XLEN){1'b0}});
  assign rem_sh  = {acc_q[2*XLEN-1:XLEN], sh_q[XLEN-1]};
  assign diff    = {1'b0, rem_sh} - {2'b00, opnd_q};
  assign acc_div = diff[XLEN+1] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  // Sign fix-up and result selection for the FINISH cycle
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fin_result;
  logic              sign_diff;

  assign sign_diff = a_neg_q ^ b_neg_q;
  assign prod_fix  = neg2_if(sign_diff, acc_q);

  always_comb begin
    fin_result = '0;
    case (op_q)
      3'd0:       fin_result = acc_q[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       fin_result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5: fin_result = (opnd_q == '0) ? {XLEN{1'b1}}
                                              : neg_if(sign_diff, acc_q[XLEN-1:0]);
      default:    fin_result = neg_if(a_neg_q, acc_q[2*XLEN-1:XLEN]);
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and busy output
  always_comb begin
    state_nxt = state;
    bus.busy  = (state != IDLE);
    case (state)
      IDLE:    if (bus.start) state_nxt = early_out ? FINISH : CALC;
      CALC:    if (cnt_q == 5'd31) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration counter, completion pulse and held write-back values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= (state == FINISH);
      if (state == IDLE && bus.start) cnt_q <= '0;
      else if (state == CALC)         cnt_q <= cnt_q + 5'd1;
      if (state == FINISH) begin
        result_q <= fin_result;
        rd_out_q <= rd_q;
      end
    end
  end

  // Operand capture at launch, one shift-add / shift-subtract step per CALC cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      op_q    <= bus.funct3;
      rd_q    <= bus.rd_in;
      a_neg_q <= a_neg_in;
      b_neg_q <= b_neg_in;
      sh_q    <= is_div_in ? a_abs_in : b_abs_in;
      opnd_q  <= is_div_in ? b_abs_in : a_abs_in;
      acc_q   <= acc_init;
    end else if (state == CALC) begin
      acc_q <= op_q[2] ? acc_div : acc_mul;
      sh_q  <= {sh_q[XLEN-2:0], 1'b0};
    end
  end

  assign bus.done   = done_q;
  assign bus.ru_wr  = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors for the iterative multiply/divide unit.
// The driver pushes the expected {rd, result} per launch; a monitor pops and
// compares on every completion pulse.
module tb_mdu_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mdu_if #(.XLEN(32), .RD_W(5)) bus ();

  mdu_iter #(.XLEN(32), .RD_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef MDU_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  int checks = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  // Monitor: every completion is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("result", bus.result, e[31:0]);
        chk("rd_out", {27'd0, bus.rd_out}, {27'd0, e[36:32]});
        chk("ru_wr", {31'd0, bus.ru_wr}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat,
                       input int poke_at);
    int cycles;
    bit got;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.rs1_val = a; bus.rs2_val = b; bus.rd_in = rd;
    exp_q.push_back({rd, res});
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.rs1_val = $urandom; bus.rs2_val = $urandom; bus.rd_in = 5'($urandom);
    bus.funct3 = 3'($urandom);
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    cycles = 0;
    got = 0;
    while (!got && cycles < 100) begin
      if (poke_at > 0 && cycles == poke_at) begin
        bus.start = 1'b1; bus.funct3 = 3'd5;
        bus.rs1_val = 32'd1000; bus.rs2_val = 32'd3; bus.rd_in = 5'd30;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (bus.done) got = 1;
    end
    bus.start = 1'b0;
    chk("latency", cycles, lat);
    chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.funct3 = '0; bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_ru_wr", {31'd0, bus.ru_wr}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_rd_out", {27'd0, bus.rd_out}, 32'd0);
    rst_n = 1'b1;

    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33, 0);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 33, 0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, 33, 0);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 33, 0);
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000001, 33, 0);
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 33, 0);
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 33, 0);
    issue(3'd5, 32'hFFFFFFF9, 32'd2, 5'd8, 32'h7FFFFFFC, 33, 0);
    issue(3'd7, 32'hFFFFFFF9, 32'd2, 5'd9, 32'h00000001, 33, 0);
    issue(3'd5, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, EO_LAT, 0);
    issue(3'd6, 32'd5, 32'd0, 5'd11, 32'd5, EO_LAT, 0);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, EO_LAT, 0);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, EO_LAT, 0);
    issue(3'd4, 32'd100, 32'd7, 5'd14, 32'd14, 33, 10);
    issue(3'd0, 32'd0, 32'd5, 5'd0, 32'd0, EO_LAT, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_val = 32'd3; bus.rs2_val = 32'd5; bus.rd_in = 5'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_rd_out", {27'd0, bus.rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 32'd6, 32'd7, 5'd7, 32'd42, 33, 0);

    issue(3'd4, 32'd9, 32'd0, 5'd15, 32'hFFFFFFFF, EO_LAT, 0);
    issue(3'd0, 32'd0, 32'd123, 5'd16, 32'd0, EO_LAT, 0);
    issue(3'd4, 32'd9, 32'd2, 5'd17, 32'd4, 33, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
